// File: rtl/uart_tx_if.sv
// uart_tx_if: character handshake and serial-line status between a producer and uart_tx.
interface uart_tx_if;
    logic [6:0] data_in;
    logic       par_inj;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output data_in, par_inj, valid, input ready, tx, busy, done);
    modport slave  (input data_in, par_inj, valid, output ready, tx, busy, done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 7E2 UART transmitter with a one-entry holding register and parity error injection.
module uart_tx #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [2:0]  r_bit, w_bit_n;
    logic [6:0]  r_shift, w_shift_n, r_hold;
    logic        r_par, w_par_n, r_hold_inj, r_full, r_tx;
    logic        w_tx_n, w_tick, w_load, w_accept;

    assign w_tick     = r_cnt == 16'(CLK_PER_BIT - 1);
    assign w_accept   = bus.valid && !r_full;
    assign bus.ready  = !r_full;
    assign bus.tx     = r_tx;
    assign bus.busy   = r_state != IDLE;
    assign bus.done   = r_state == STOP && r_bit == 3'd1 && w_tick;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = (r_state == IDLE || w_tick) ? 16'd0 : r_cnt + 16'd1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_load    = 1'b0;
        case (r_state)
            IDLE:   if (r_full) begin
                        w_state_n = START;
                        w_load    = 1'b1;
                    end
            START:  if (w_tick) begin
                        w_state_n = DATA;
                        w_bit_n   = 3'd0;
                    end
            DATA:   if (w_tick) begin
                        w_shift_n = r_shift >> 1;
                        w_bit_n   = r_bit + 3'd1;
                        w_state_n = (r_bit == 3'd6) ? PARITY : DATA;
                    end
            PARITY: if (w_tick) begin
                        w_state_n = STOP;
                        w_bit_n   = 3'd0;
                    end
            STOP:   if (w_tick) begin
                        w_bit_n = r_bit + 3'd1;
                        if (r_bit == 3'd1) begin
                            w_state_n = r_full ? START : IDLE;
                            w_load    = r_full;
                        end
                    end
            default: w_state_n = IDLE;
        endcase
        if (w_load) begin
            w_shift_n = r_hold;
            w_par_n   = ^r_hold ^ r_hold_inj;
        end
        // tx is registered, so it is derived from the state being entered
        w_tx_n = w_state_n == START  ? 1'b0 :
                 w_state_n == DATA   ? w_shift_n[0] :
                 w_state_n == PARITY ? w_par_n : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_hold     <= '0;
            r_hold_inj <= 1'b0;
            r_full     <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_tx    <= w_tx_n;
            r_full  <= w_load ? 1'b0 : (w_accept ? 1'b1 : r_full);
            if (w_accept) begin
                r_hold     <= bus.data_in;
                r_hold_inj <= bus.par_inj;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, handshake, reset abort and a loopback receiver model.
module tb_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if bus ();
    uart_tx #(.CLK_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_chk = 0;
    int         n_pass = 0;
    int         rx_n = 0;
    int         n0;
    logic [6:0] rx_d [0:31];
    logic       rx_e [0:31];
    logic [8:0] rx_s;

    // Independent receiver: mid-bit sampling, flags parity or stop errors
    initial forever begin
        @(negedge bus.tx);
        if (!rst) begin
            repeat (CPB / 2) @(posedge clk);
            #1;
            for (int b = 0; b < 9; b++) begin
                repeat (CPB) @(posedge clk);
                #1;
                rx_s[b] = bus.tx;
            end
            rx_d[rx_n] = rx_s[6:0];
            rx_e[rx_n] = (^rx_s[7:0]) | !rx_s[8];
            rx_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] d, input logic inj, input string tag);
        bus.data_in = d;
        bus.par_inj = inj;
        bus.valid   = 1'b1;
        chk({tag, "_rdy_k"}, 32'(bus.ready), 1);
        step();
        bus.valid = 1'b0;
        chk({tag, "_tx_k1"}, 32'(bus.tx), 1);
        chk({tag, "_rdy_k1"}, 32'(bus.ready), 0);
        chk({tag, "_busy_k1"}, 32'(bus.busy), 0);
        step();
        chk({tag, "_rdy_k2"}, 32'(bus.ready), 1);
    endtask

    task automatic frame(input logic [6:0] d, input logic p, input string tag,
                         input int acc_at, input logic [6:0] nd, input logic hold, input logic [6:0] hd);
        logic [10:0] bits;
        bits = {2'b11, p, d, 1'b0};
        for (int i = 0; i < 11 * CPB; i++) begin
            if (acc_at >= 0 && i == acc_at) begin
                bus.data_in = nd;
                bus.par_inj = 1'b0;
                bus.valid   = 1'b1;
            end
            if (acc_at >= 0 && i == acc_at + 1) begin
                if (hold) bus.data_in = hd;
                else bus.valid = 1'b0;
            end
            chk($sformatf("%s_tx%0d", tag, i), 32'(bus.tx), 32'(bits[i / CPB]));
            chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 1);
            chk($sformatf("%s_done%0d", tag, i), 32'(bus.done), 32'(i == 11 * CPB - 1));
            chk($sformatf("%s_rdy%0d", tag, i), 32'(bus.ready), 32'(acc_at < 0 || i <= acc_at));
            step();
        end
    endtask

    task automatic rxchk(input string tag, input int idx, input logic [6:0] d, input logic e);
        chk({tag, "_rxd"}, 32'(rx_d[idx]), 32'(d));
        chk({tag, "_rxe"}, 32'(rx_e[idx]), 32'(e));
    endtask

    initial begin
        bus.valid   = 1'b0;
        bus.data_in = '0;
        bus.par_inj = 1'b0;
        repeat (3) step();
        chk("rst_tx", 32'(bus.tx), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rdy", 32'(bus.ready), 1);
        rst = 1'b0;
        repeat (2) step();

        n0 = rx_n;
        send(7'h41, 1'b0, "a41");
        frame(7'h41, 1'b0, "a41", -1, 7'h00, 1'b0, 7'h00);
        chk("a41_idle_busy", 32'(bus.busy), 0);
        chk("a41_idle_tx", 32'(bus.tx), 1);
        chk("a41_rxn", 32'(rx_n), 32'(n0 + 1));
        rxchk("a41", n0, 7'h41, 1'b0);
        repeat (3) step();

        n0 = rx_n;
        send(7'h07, 1'b0, "p07");
        frame(7'h07, 1'b1, "p07", -1, 7'h00, 1'b0, 7'h00);
        rxchk("p07", n0, 7'h07, 1'b0);
        send(7'h07, 1'b1, "i07");
        frame(7'h07, 1'b0, "i07", -1, 7'h00, 1'b0, 7'h00);
        rxchk("i07", n0 + 1, 7'h07, 1'b1);
        repeat (3) step();

        n0 = rx_n;
        send(7'h55, 1'b0, "b55");
        frame(7'h55, 1'b0, "b55", 4, 7'h2A, 1'b1, 7'h33);
        frame(7'h2A, 1'b1, "b2A", 0, 7'h33, 1'b0, 7'h00);
        frame(7'h33, 1'b0, "b33", -1, 7'h00, 1'b0, 7'h00);
        chk("b_idle_busy", 32'(bus.busy), 0);
        chk("b_rxn", 32'(rx_n), 32'(n0 + 3));
        rxchk("b55", n0, 7'h55, 1'b0);
        rxchk("b2A", n0 + 1, 7'h2A, 1'b0);
        rxchk("b33", n0 + 2, 7'h33, 1'b0);
        repeat (3) step();

        send(7'h15, 1'b0, "r15");
        for (int i = 0; i < 12; i++) begin
            bus.data_in = 7'h6B;
            bus.valid   = (i == 2);
            step();
        end
        bus.valid = 1'b0;
        chk("r_pre_busy", 32'(bus.busy), 1);
        chk("r_pre_rdy", 32'(bus.ready), 0);
        rst = 1'b1;
        #1;
        chk("r_tx", 32'(bus.tx), 1);
        chk("r_busy", 32'(bus.busy), 0);
        chk("r_rdy", 32'(bus.ready), 1);
        chk("r_done", 32'(bus.done), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("r_quiet_tx%0d", i), 32'(bus.tx), 1);
            chk($sformatf("r_quiet_done%0d", i), 32'(bus.done), 0);
            chk($sformatf("r_quiet_busy%0d", i), 32'(bus.busy), 0);
            step();
        end

        n0 = rx_n;
        send(7'h5A, 1'b0, "z5A");
        frame(7'h5A, 1'b0, "z5A", -1, 7'h00, 1'b0, 7'h00);
        chk("z5A_rxn", 32'(rx_n), 32'(n0 + 1));
        rxchk("z5A", n0, 7'h5A, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
